// File: rtl/branch_tag_allocator.sv
// Branch tag allocator: hands one-hot branch tags to in-order dispatch slots and keeps
// per-tag dependency masks so a mispredict squashes every younger dependent branch.

module branch_tag_entry #(
    parameter int B_MASK_WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    set,
    input  logic [B_MASK_WIDTH-1:0] set_mask,
    input  logic                    clear,
    input  logic [B_MASK_WIDTH-1:0] dep_clr,
    output logic                    active,
    output logic [B_MASK_WIDTH-1:0] dep_mask
);
    // set and clear never coincide: set only targets free tags, clear only active ones
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active   <= 1'b0;
            dep_mask <= '0;
        end else if (set) begin
            active   <= 1'b1;
            dep_mask <= set_mask;
        end else if (clear) begin
            active   <= 1'b0;
            dep_mask <= '0;
        end else begin
            dep_mask <= dep_mask & ~dep_clr;
        end
    end
endmodule

module branch_tag_allocator #(
    parameter int B_MASK_WIDTH   = 4,
    parameter int DISPATCH_WIDTH = 2
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [DISPATCH_WIDTH-1:0]                dispatch_valid,
    input  logic [DISPATCH_WIDTH-1:0]                dispatch_is_branch,
    output logic [DISPATCH_WIDTH-1:0]                dispatch_grant,
    output logic [DISPATCH_WIDTH*B_MASK_WIDTH-1:0]   alloc_tag,
    output logic [DISPATCH_WIDTH*B_MASK_WIDTH-1:0]   inst_b_mask,
    input  logic                                     resolve_valid,
    input  logic [B_MASK_WIDTH-1:0]                  resolve_tag,
    input  logic                                     resolve_mispred,
    output logic [B_MASK_WIDTH-1:0]                  b_mm_out,
    output logic [B_MASK_WIDTH-1:0]                  squash_mask,
    output logic [B_MASK_WIDTH-1:0]                  b_mask_active,
    output logic [$clog2(B_MASK_WIDTH+1)-1:0]        free_count,
    output logic                                     stall,
    output logic                                     recovering
);
    localparam int W  = B_MASK_WIDTH;
    localparam int DW = DISPATCH_WIDTH;
    localparam int CW = $clog2(B_MASK_WIDTH+1);

    typedef enum logic {NORMAL, RECOVER} state_t;
    state_t state_q, state_d;

    logic [W-1:0]          active, squashed, cleared, dep_clr, set_vec, next_active;
    logic [W-1:0][W-1:0]   dep_mask, set_mask;
    logic                  tag_onehot, res_hit, res_ok, res_bad;
    logic [DW-1:0]         grant_c;
    logic [DW-1:0][W-1:0]  tag_c, mask_c;
    logic [CW-1:0]         free_d;

    assign tag_onehot = (resolve_tag != '0) && ((resolve_tag & (resolve_tag - W'(1))) == '0);
    assign res_hit    = resolve_valid && tag_onehot && |(resolve_tag & active);
    assign res_ok     = res_hit && !resolve_mispred;
    assign res_bad    = res_hit && resolve_mispred;

    always_comb begin
        squashed = '0;
        for (int t = 0; t < W; t++)
            squashed[t] = active[t] && (resolve_tag[t] || |(dep_mask[t] & resolve_tag));
        cleared = res_ok ? resolve_tag : (res_bad ? squashed : '0);
        dep_clr = res_ok ? resolve_tag : '0;
    end

    // Slot-ordered allocation from the registered free set; freed tags wait a cycle
    always_comb begin
        logic [W-1:0] avail, acc, pick;
        logic         ok;
        avail   = ~active;
        acc     = '0;
        ok      = reset && (state_q == NORMAL) && !res_bad;
        grant_c = '0;
        tag_c   = '0;
        mask_c  = '0;
        for (int i = 0; i < DW; i++) begin
            mask_c[i] = ((active & ~cleared) | acc) & {W{reset}};
            pick      = avail & (~avail + W'(1));
            if (dispatch_valid[i]) begin
                if (ok && (!dispatch_is_branch[i] || avail != '0)) begin
                    grant_c[i] = 1'b1;
                    if (dispatch_is_branch[i]) begin
                        tag_c[i] = pick;
                        avail    = avail & ~pick;
                        acc      = acc | pick;
                    end
                end else begin
                    ok = 1'b0;
                end
            end
        end
    end

    always_comb begin
        set_vec  = '0;
        set_mask = '0;
        for (int i = 0; i < DW; i++)
            for (int t = 0; t < W; t++)
                if (tag_c[i][t]) begin
                    set_vec[t]  = 1'b1;
                    set_mask[t] = mask_c[i];
                end
        next_active = (active & ~cleared) | set_vec;
        free_d = '0;
        for (int t = 0; t < W; t++)
            if (!next_active[t]) free_d = free_d + CW'(1);
    end

    for (genvar t = 0; t < W; t++) begin : g_entry
        branch_tag_entry #(.B_MASK_WIDTH(W)) u_entry (
            .clock    (clock),
            .reset    (reset),
            .set      (set_vec[t]),
            .set_mask (set_mask[t]),
            .clear    (cleared[t]),
            .dep_clr  (dep_clr),
            .active   (active[t]),
            .dep_mask (dep_mask[t])
        );
    end

    // Each processed mispredict buys exactly one recovery cycle
    always_comb begin
        state_d = NORMAL;
        if (res_bad) state_d = RECOVER;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= NORMAL;
            b_mm_out    <= '0;
            squash_mask <= '0;
            free_count  <= CW'(W);
        end else begin
            state_q     <= state_d;
            b_mm_out    <= res_hit ? resolve_tag : '0;
            squash_mask <= res_bad ? squashed : '0;
            free_count  <= free_d;
        end
    end

    assign dispatch_grant = grant_c;
    assign alloc_tag      = tag_c;
    assign inst_b_mask    = mask_c;
    assign b_mask_active  = active;
    assign stall          = reset && |(dispatch_valid & ~grant_c);
    assign recovering     = reset && (state_q == RECOVER);
endmodule

// File: tb/tb_branch_tag_allocator.sv
// Scenario bench for branch_tag_allocator: each step's expected outputs are queued when
// driven and popped when the DUT outputs are sampled.
module tb_branch_tag_allocator;
    localparam int W  = 4;
    localparam int DW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] dispatch_valid, dispatch_is_branch, dispatch_grant;
    logic [DW*W-1:0] alloc_tag, inst_b_mask;
    logic          resolve_valid, resolve_mispred;
    logic [W-1:0]  resolve_tag, b_mm_out, squash_mask, b_mask_active;
    logic [2:0]    free_count;
    logic          stall, recovering;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] dv, db;
        logic       rv;
        logic [3:0] rt;
        logic       rm;
        logic [1:0] g;
        logic [7:0] tag, mask;
        logic       st, rec;
        logic [3:0] act;
        logic [2:0] free;
        logic [3:0] bmm, sq;
    } step_t;

    step_t exp_q[$];

    branch_tag_allocator #(.B_MASK_WIDTH(W), .DISPATCH_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_is_branch(dispatch_is_branch),
        .dispatch_grant(dispatch_grant), .alloc_tag(alloc_tag), .inst_b_mask(inst_b_mask),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_mispred(resolve_mispred),
        .b_mm_out(b_mm_out), .squash_mask(squash_mask), .b_mask_active(b_mask_active),
        .free_count(free_count), .stall(stall), .recovering(recovering)
    );

    always #5 clock = ~clock;

    task automatic drive(input step_t s);
        dispatch_valid     = s.dv;
        dispatch_is_branch = s.db;
        resolve_valid      = s.rv;
        resolve_tag        = s.rt;
        resolve_mispred    = s.rm;
        exp_q.push_back(s);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        dispatch_valid = 2'b11; dispatch_is_branch = 2'b11;
        resolve_valid = 1'b1; resolve_tag = 4'b0001; resolve_mispred = 1'b1;
        #12;
        checks++;
        if ({dispatch_grant, alloc_tag, inst_b_mask, stall, recovering} !== 20'h0) begin
            errors++;
            $display("FAIL reset_comb: got %h expected %h",
                     {dispatch_grant, alloc_tag, inst_b_mask, stall, recovering}, 20'h0);
        end
        checks++;
        if ({b_mask_active, free_count, b_mm_out, squash_mask} !== {4'h0, 3'd4, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h",
                     {b_mask_active, free_count, b_mm_out, squash_mask}, {4'h0, 3'd4, 4'h0, 4'h0});
        end
        @(negedge clock);
        dispatch_valid = '0; dispatch_is_branch = '0; resolve_valid = 1'b0;
        resolve_tag = '0; resolve_mispred = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    // Two branches in one cycle, then a third branch depending on both
    task automatic test_dual_branch;
        step_t s[2] = '{
            '{2'b11, 2'b11, 1'b0, 4'h0, 1'b0, 2'b11, 8'h21, 8'h10, 1'b0, 1'b0, 4'b0011, 3'd2, 4'h0, 4'h0},
            '{2'b01, 2'b01, 1'b0, 4'h0, 1'b0, 2'b01, 8'h04, 8'h73, 1'b0, 1'b0, 4'b0111, 3'd1, 4'h0, 4'h0}};
        foreach (s[k]) begin
            step_t e;
            drive(s[k]);
            @(negedge clock); e = exp_q.pop_front();
            checks++;
            if ({dispatch_grant, alloc_tag, inst_b_mask, stall, recovering} !== {e.g, e.tag, e.mask, e.st, e.rec}) begin
                errors++;
                $display("FAIL dual_branch[%0d] comb: got %h expected %h", k,
                         {dispatch_grant, alloc_tag, inst_b_mask, stall, recovering}, {e.g, e.tag, e.mask, e.st, e.rec});
            end
            @(posedge clock); #1;
            checks++;
            if ({b_mask_active, free_count, b_mm_out, squash_mask} !== {e.act, e.free, e.bmm, e.sq}) begin
                errors++;
                $display("FAIL dual_branch[%0d] state: got %h expected %h", k,
                         {b_mask_active, free_count, b_mm_out, squash_mask}, {e.act, e.free, e.bmm, e.sq});
            end
        end
    endtask

    // Chain 0<-1<-2, mispredict tag 0 squashes all three and blocks two cycles of dispatch
    task automatic test_mispredict;
        step_t s[3] = '{
            '{2'b11, 2'b00, 1'b1, 4'b0001, 1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 4'b0000, 3'd4, 4'b0001, 4'b0111},
            '{2'b11, 2'b00, 1'b0, 4'h0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 4'b0000, 3'd4, 4'h0, 4'h0},
            '{2'b11, 2'b00, 1'b0, 4'h0, 1'b0, 2'b11, 8'h00, 8'h00, 1'b0, 1'b0, 4'b0000, 3'd4, 4'h0, 4'h0}};
        foreach (s[k]) begin
            step_t e;
            drive(s[k]);
            @(negedge clock); e = exp_q.pop_front();
            checks++;
            if ({dispatch_grant, alloc_tag, inst_b_mask, stall, recovering} !== {e.g, e.tag, e.mask, e.st, e.rec}) begin
                errors++;
                $display("FAIL mispredict[%0d] comb: got %h expected %h", k,
                         {dispatch_grant, alloc_tag, inst_b_mask, stall, recovering}, {e.g, e.tag, e.mask, e.st, e.rec});
            end
            @(posedge clock); #1;
            checks++;
            if ({b_mask_active, free_count, b_mm_out, squash_mask} !== {e.act, e.free, e.bmm, e.sq}) begin
                errors++;
                $display("FAIL mispredict[%0d] state: got %h expected %h", k,
                         {b_mask_active, free_count, b_mm_out, squash_mask}, {e.act, e.free, e.bmm, e.sq});
            end
        end
    endtask

    // Independent tags: mispredict tag 1 spares tag 0; a second mispredict in RECOVER extends it
    task automatic test_recover_extend;
        step_t s[5] = '{
            '{2'b11, 2'b11, 1'b0, 4'h0, 1'b0, 2'b11, 8'h21, 8'h10, 1'b0, 1'b0, 4'b0011, 3'd2, 4'h0, 4'h0},
            '{2'b00, 2'b00, 1'b1, 4'b0010, 1'b1, 2'b00, 8'h00, 8'h11, 1'b0, 1'b0, 4'b0001, 3'd3, 4'b0010, 4'b0010},
            '{2'b01, 2'b00, 1'b1, 4'b0001, 1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 4'b0000, 3'd4, 4'b0001, 4'b0001},
            '{2'b01, 2'b00, 1'b0, 4'h0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 4'b0000, 3'd4, 4'h0, 4'h0},
            '{2'b01, 2'b00, 1'b0, 4'h0, 1'b0, 2'b01, 8'h00, 8'h00, 1'b0, 1'b0, 4'b0000, 3'd4, 4'h0, 4'h0}};
        foreach (s[k]) begin
            step_t e;
            drive(s[k]);
            @(negedge clock); e = exp_q.pop_front();
            checks++;
            if ({dispatch_grant, alloc_tag, inst_b_mask, stall, recovering} !== {e.g, e.tag, e.mask, e.st, e.rec}) begin
                errors++;
                $display("FAIL recover_extend[%0d] comb: got %h expected %h", k,
                         {dispatch_grant, alloc_tag, inst_b_mask, stall, recovering}, {e.g, e.tag, e.mask, e.st, e.rec});
            end
            @(posedge clock); #1;
            checks++;
            if ({b_mask_active, free_count, b_mm_out, squash_mask} !== {e.act, e.free, e.bmm, e.sq}) begin
                errors++;
                $display("FAIL recover_extend[%0d] state: got %h expected %h", k,
                         {b_mask_active, free_count, b_mm_out, squash_mask}, {e.act, e.free, e.bmm, e.sq});
            end
        end
    endtask

    // Fill all four tags, then branches are refused while an older non-branch still goes
    task automatic test_full;
        step_t s[4] = '{
            '{2'b11, 2'b11, 1'b0, 4'h0, 1'b0, 2'b11, 8'h21, 8'h10, 1'b0, 1'b0, 4'b0011, 3'd2, 4'h0, 4'h0},
            '{2'b11, 2'b11, 1'b0, 4'h0, 1'b0, 2'b11, 8'h84, 8'h73, 1'b0, 1'b0, 4'b1111, 3'd0, 4'h0, 4'h0},
            '{2'b11, 2'b10, 1'b0, 4'h0, 1'b0, 2'b01, 8'h00, 8'hFF, 1'b1, 1'b0, 4'b1111, 3'd0, 4'h0, 4'h0},
            '{2'b11, 2'b01, 1'b0, 4'h0, 1'b0, 2'b00, 8'h00, 8'hFF, 1'b1, 1'b0, 4'b1111, 3'd0, 4'h0, 4'h0}};
        foreach (s[k]) begin
            step_t e;
            drive(s[k]);
            @(negedge clock); e = exp_q.pop_front();
            checks++;
            if ({dispatch_grant, alloc_tag, inst_b_mask, stall, recovering} !== {e.g, e.tag, e.mask, e.st, e.rec}) begin
                errors++;
                $display("FAIL full[%0d] comb: got %h expected %h", k,
                         {dispatch_grant, alloc_tag, inst_b_mask, stall, recovering}, {e.g, e.tag, e.mask, e.st, e.rec});
            end
            @(posedge clock); #1;
            checks++;
            if ({b_mask_active, free_count, b_mm_out, squash_mask} !== {e.act, e.free, e.bmm, e.sq}) begin
                errors++;
                $display("FAIL full[%0d] state: got %h expected %h", k,
                         {b_mask_active, free_count, b_mm_out, squash_mask}, {e.act, e.free, e.bmm, e.sq});
            end
        end
    endtask

    // Correct resolves drain to 0011; resolve+alloc same cycle; mispredict of tag 1 proves dep_mask[2]=0010
    task automatic test_resolve_same_cycle;
        step_t s[5] = '{
            '{2'b00, 2'b00, 1'b1, 4'b1000, 1'b0, 2'b00, 8'h00, 8'h77, 1'b0, 1'b0, 4'b0111, 3'd1, 4'b1000, 4'h0},
            '{2'b00, 2'b00, 1'b1, 4'b0100, 1'b0, 2'b00, 8'h00, 8'h33, 1'b0, 1'b0, 4'b0011, 3'd2, 4'b0100, 4'h0},
            '{2'b01, 2'b01, 1'b1, 4'b0001, 1'b0, 2'b01, 8'h04, 8'h62, 1'b0, 1'b0, 4'b0110, 3'd2, 4'b0001, 4'h0},
            '{2'b00, 2'b00, 1'b1, 4'b0010, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 4'b0000, 3'd4, 4'b0010, 4'b0110},
            '{2'b00, 2'b00, 1'b0, 4'h0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 4'b0000, 3'd4, 4'h0, 4'h0}};
        foreach (s[k]) begin
            step_t e;
            drive(s[k]);
            @(negedge clock); e = exp_q.pop_front();
            checks++;
            if ({dispatch_grant, alloc_tag, inst_b_mask, stall, recovering} !== {e.g, e.tag, e.mask, e.st, e.rec}) begin
                errors++;
                $display("FAIL resolve_same_cycle[%0d] comb: got %h expected %h", k,
                         {dispatch_grant, alloc_tag, inst_b_mask, stall, recovering}, {e.g, e.tag, e.mask, e.st, e.rec});
            end
            @(posedge clock); #1;
            checks++;
            if ({b_mask_active, free_count, b_mm_out, squash_mask} !== {e.act, e.free, e.bmm, e.sq}) begin
                errors++;
                $display("FAIL resolve_same_cycle[%0d] state: got %h expected %h", k,
                         {b_mask_active, free_count, b_mm_out, squash_mask}, {e.act, e.free, e.bmm, e.sq});
            end
        end
    endtask

    // Resolves of an inactive tag or a non-one-hot tag change nothing
    task automatic test_ignored;
        step_t s[4] = '{
            '{2'b01, 2'b01, 1'b0, 4'h0, 1'b0, 2'b01, 8'h01, 8'h10, 1'b0, 1'b0, 4'b0001, 3'd3, 4'h0, 4'h0},
            '{2'b01, 2'b00, 1'b1, 4'b1000, 1'b1, 2'b01, 8'h00, 8'h11, 1'b0, 1'b0, 4'b0001, 3'd3, 4'h0, 4'h0},
            '{2'b00, 2'b00, 1'b1, 4'b0011, 1'b0, 2'b00, 8'h00, 8'h11, 1'b0, 1'b0, 4'b0001, 3'd3, 4'h0, 4'h0},
            '{2'b01, 2'b00, 1'b0, 4'h0, 1'b0, 2'b01, 8'h00, 8'h11, 1'b0, 1'b0, 4'b0001, 3'd3, 4'h0, 4'h0}};
        foreach (s[k]) begin
            step_t e;
            drive(s[k]);
            @(negedge clock); e = exp_q.pop_front();
            checks++;
            if ({dispatch_grant, alloc_tag, inst_b_mask, stall, recovering} !== {e.g, e.tag, e.mask, e.st, e.rec}) begin
                errors++;
                $display("FAIL ignored[%0d] comb: got %h expected %h", k,
                         {dispatch_grant, alloc_tag, inst_b_mask, stall, recovering}, {e.g, e.tag, e.mask, e.st, e.rec});
            end
            @(posedge clock); #1;
            checks++;
            if ({b_mask_active, free_count, b_mm_out, squash_mask} !== {e.act, e.free, e.bmm, e.sq}) begin
                errors++;
                $display("FAIL ignored[%0d] state: got %h expected %h", k,
                         {b_mask_active, free_count, b_mm_out, squash_mask}, {e.act, e.free, e.bmm, e.sq});
            end
        end
    endtask

    // Reset in the middle of RECOVER clears everything without a clock edge
    task automatic test_reset_recover;
        step_t e;
        drive('{2'b00, 2'b00, 1'b1, 4'b0001, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 4'b0000, 3'd4, 4'b0001, 4'b0001});
        @(posedge clock); #1; e = exp_q.pop_front();
        checks++;
        if ({b_mask_active, free_count, b_mm_out, squash_mask} !== {e.act, e.free, e.bmm, e.sq}) begin
            errors++;
            $display("FAIL reset_recover pre: got %h expected %h",
                     {b_mask_active, free_count, b_mm_out, squash_mask}, {e.act, e.free, e.bmm, e.sq});
        end
        dispatch_valid = 2'b11; dispatch_is_branch = 2'b11; resolve_valid = 1'b0;
        #1;
        checks++;
        if ({recovering, dispatch_grant, stall} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_recover in_recover: got %b expected %b", {recovering, dispatch_grant, stall}, 4'b1001);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({dispatch_grant, alloc_tag, inst_b_mask, stall, recovering} !== 20'h0) begin
            errors++;
            $display("FAIL reset_recover comb: got %h expected %h",
                     {dispatch_grant, alloc_tag, inst_b_mask, stall, recovering}, 20'h0);
        end
        checks++;
        if ({b_mask_active, free_count, b_mm_out, squash_mask} !== {4'h0, 3'd4, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_recover state: got %h expected %h",
                     {b_mask_active, free_count, b_mm_out, squash_mask}, {4'h0, 3'd4, 4'h0, 4'h0});
        end
        dispatch_valid = '0; dispatch_is_branch = '0;
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        drive('{2'b01, 2'b01, 1'b0, 4'h0, 1'b0, 2'b01, 8'h01, 8'h10, 1'b0, 1'b0, 4'b0001, 3'd3, 4'h0, 4'h0});
        @(negedge clock); e = exp_q.pop_front();
        checks++;
        if ({dispatch_grant, alloc_tag, inst_b_mask, stall, recovering} !== {e.g, e.tag, e.mask, e.st, e.rec}) begin
            errors++;
            $display("FAIL reset_recover post comb: got %h expected %h",
                     {dispatch_grant, alloc_tag, inst_b_mask, stall, recovering}, {e.g, e.tag, e.mask, e.st, e.rec});
        end
        @(posedge clock); #1;
        checks++;
        if ({b_mask_active, free_count, b_mm_out, squash_mask} !== {e.act, e.free, e.bmm, e.sq}) begin
            errors++;
            $display("FAIL reset_recover post state: got %h expected %h",
                     {b_mask_active, free_count, b_mm_out, squash_mask}, {e.act, e.free, e.bmm, e.sq});
        end
    endtask

    initial begin
        test_reset;
        test_dual_branch;
        test_mispredict;
        test_recover_extend;
        test_full;
        test_resolve_same_cycle;
        test_ignored;
        test_reset_recover;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
